// File: rtl/encoder_pkg.sv
// Shared widths, FSM state type and popcount helper for the 16-bit set-bit stream encoder.
package encoder_pkg;

    localparam int unsigned VEC_W = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 5;

    typedef enum logic {
        IDLE,
        EMIT
    } state_e;

    // Number of set bits in a vector; CNT_W holds 0..16 without wrapping.
    function automatic logic [CNT_W-1:0] popcount(input logic [VEC_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < VEC_W; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/encoder16_stream_if.sv
// Producer (bitmap in) and consumer (index beats out) handshake bundle.
interface encoder16_stream_if;
    import encoder_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [VEC_W-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_none;
    logic [CNT_W-1:0] out_count;

    // Encoder side.
    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_none, out_count
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_none, out_count
    );

endinterface

// File: rtl/prio_find16.sv
// Combinational finder: index of the lowest (direction=1) or highest (direction=0) set bit.
module prio_find16
    import encoder_pkg::*;
(
    input  logic [VEC_W-1:0] mask,
    input  logic             direction,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan so that the last matching assignment is the winning bit.
    always_comb begin
        idx   = '0;
        found = |mask;
        if (direction) begin
            for (int i = VEC_W - 1; i >= 0; i--) begin
                if (mask[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < VEC_W; i++) begin
                if (mask[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/encoder16_stream.sv
// Captures a 16-bit bitmap and streams the index of each set bit, one beat per accept.
module encoder16_stream
    import encoder_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    encoder16_stream_if.slave bus
);

    state_e           state_q;
    logic [VEC_W-1:0] mask_q;
    logic [CNT_W-1:0] count_q;
    logic             none_q;

    logic [IDX_W-1:0] find_idx;
    logic             find_found;
    logic             single;
    logic             last;
    logic             emit;

    prio_find16 u_find (
        .mask      (mask_q),
        .direction (LSB_FIRST),
        .idx       (find_idx),
        .found     (find_found)
    );

    // Final beat: one pending bit left, or the single beat of an all-zero vector.
    always_comb begin
        emit   = (state_q == EMIT);
        single = ((mask_q & (mask_q - VEC_W'(1))) == '0);
        last   = emit & (~find_found | single);
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = emit;
    assign bus.out_idx   = find_idx;
    assign bus.out_last  = last;
    assign bus.out_none  = emit & none_q;
    assign bus.out_count = count_q;

    // Capture in IDLE, retire one pending bit per accepted beat in EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            count_q <= '0;
            none_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mask_q  <= bus.in_vec;
                        count_q <= popcount(bus.in_vec);
                        none_q  <= (bus.in_vec == '0);
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (last) begin
                            mask_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            mask_q <= mask_q & ~(VEC_W'(1) << find_idx);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder16_stream.sv
// Bench: two encoders (LSB-first and MSB-first) driven in lockstep, checked every cycle
// against a queue-based model of the expected index stream.
module tb_encoder16_stream;
    import encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_vec = '0;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit  m_busy = 1'b0;
    bit  m_none = 1'b0;
    int  m_count = 0;
    int  q_l[$];
    int  q_m[$];

    always #5 clk = ~clk;

    encoder16_stream_if bus_l ();
    encoder16_stream_if bus_m ();

    assign bus_l.in_valid  = in_valid;
    assign bus_l.in_vec    = in_vec;
    assign bus_l.out_ready = out_ready;
    assign bus_m.in_valid  = in_valid;
    assign bus_m.in_vec    = in_vec;
    assign bus_m.out_ready = out_ready;

    encoder16_stream #(.LSB_FIRST(1'b1)) dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l.slave)
    );

    encoder16_stream #(.LSB_FIRST(1'b0)) dut_m (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_m.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        q_l.delete();
        q_m.delete();
    endtask

    // One clock edge of the behavioural model, using the inputs present at that edge.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            if (in_valid) begin
                q_l.delete();
                q_m.delete();
                m_count = 0;
                for (int i = 0; i < 16; i++) begin
                    if (in_vec[i]) begin
                        q_l.push_back(i);
                        q_m.push_front(i);
                        m_count++;
                    end
                end
                m_none = (m_count == 0);
                if (m_none) begin
                    q_l.push_back(0);
                    q_m.push_back(0);
                end
                m_busy = 1'b1;
            end
        end else if (out_ready) begin
            void'(q_l.pop_front());
            void'(q_m.pop_front());
            if (q_l.size() == 0) m_busy = 1'b0;
        end
    endtask

    task automatic check_all();
        check("lsb:in_ready", 32'(bus_l.in_ready), 32'(!m_busy));
        check("lsb:out_valid", 32'(bus_l.out_valid), 32'(m_busy));
        check("msb:in_ready", 32'(bus_m.in_ready), 32'(!m_busy));
        check("msb:out_valid", 32'(bus_m.out_valid), 32'(m_busy));
        if (m_busy) begin
            check("lsb:idx", 32'(bus_l.out_idx), 32'(q_l[0]));
            check("msb:idx", 32'(bus_m.out_idx), 32'(q_m[0]));
            check("lsb:last", 32'(bus_l.out_last), 32'(q_l.size() == 1));
            check("msb:last", 32'(bus_m.out_last), 32'(q_m.size() == 1));
            check("lsb:none", 32'(bus_l.out_none), 32'(m_none));
            check("msb:none", 32'(bus_m.out_none), 32'(m_none));
            check("lsb:count", 32'(bus_l.out_count), 32'(m_count));
            check("msb:count", 32'(bus_m.out_count), 32'(m_count));
        end
    endtask

    task automatic check_reset();
        check("rst:lsb:in_ready", 32'(bus_l.in_ready), 32'd1);
        check("rst:lsb:out_valid", 32'(bus_l.out_valid), 32'd0);
        check("rst:lsb:idx", 32'(bus_l.out_idx), 32'd0);
        check("rst:lsb:last", 32'(bus_l.out_last), 32'd0);
        check("rst:lsb:none", 32'(bus_l.out_none), 32'd0);
        check("rst:lsb:count", 32'(bus_l.out_count), 32'd0);
        check("rst:msb:in_ready", 32'(bus_m.in_ready), 32'd1);
        check("rst:msb:out_valid", 32'(bus_m.out_valid), 32'd0);
        check("rst:msb:idx", 32'(bus_m.out_idx), 32'd0);
        check("rst:msb:last", 32'(bus_m.out_last), 32'd0);
        check("rst:msb:none", 32'(bus_m.out_none), 32'd0);
        check("rst:msb:count", 32'(bus_m.out_count), 32'd0);
    endtask

    // Advance one clock, update the model, then sample just after the edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Present a vector for one cycle, then drain the burst with the chosen ready pattern.
    task automatic send(input logic [15:0] vec, input int stall, input bit rnd_ready,
                        input bit hold_valid);
        int k;
        in_valid  = 1'b1;
        in_vec    = vec;
        out_ready = 1'b1;
        cycle();
        in_valid = hold_valid;
        k = 0;
        while (m_busy && k < 80) begin
            if (k < stall) out_ready = 1'b0;
            else if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 1'b1;
            if (hold_valid) in_vec = 16'($urandom);
            cycle();
            k++;
        end
        check("burst_done", 32'(m_busy), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cycle();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check_reset();
        model_reset();
        cycle();
        #2 rst_n = 1'b1;
        cycle();

        // All-zero vector, 0x8421 in both orders, stalled two-bit vector, full vector.
        send(16'h0000, 0, 1'b0, 1'b0);
        send(16'h8421, 0, 1'b0, 1'b0);
        send(16'h0090, 5, 1'b0, 1'b0);
        send(16'hFFFF, 0, 1'b0, 1'b0);
        send(16'h0001, 0, 1'b0, 1'b0);
        send(16'h8000, 2, 1'b0, 1'b0);

        // Changing in_vec with in_valid held during the burst must be ignored.
        send(16'h1248, 0, 1'b0, 1'b1);
        send(16'hA5A5, 1, 1'b1, 1'b1);

        // Reset mid-burst after three accepted beats of 0xFFFF.
        in_valid  = 1'b1;
        in_vec    = 16'hFFFF;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset();
        cycle();
        #2 rst_n = 1'b1;
        cycle();
        cycle();
        send(16'h0002, 0, 1'b0, 1'b0);

        // Randomized vectors with mixed density and random backpressure.
        for (int n = 0; n < 40; n++) begin
            logic [15:0] v;
            case ($urandom_range(0, 3))
                0: v = 16'($urandom) & 16'($urandom) & 16'($urandom);
                1: v = 16'($urandom);
                2: v = 16'($urandom) | 16'($urandom);
                default: v = 16'd1 << $urandom_range(0, 15);
            endcase
            send(v, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder16_stream.md
ENCODER16_STREAM -- requirements
Module: encoder16_stream

Interface
REQ-001 The block SHALL have parameter LSB_FIRST, default 1, meaning 1 = emit lowest set bit index first and 0 = emit highest first.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid  input  1  in_vec is presented.
REQ-005 The block SHALL have port in_ready  output  1  block accepts a new vector.
REQ-006 The block SHALL have port in_vec  input  16  one-hot or multi-hot bitmap to encode.
REQ-007 The block SHALL have port out_valid  output  1  out_idx beat is valid.
REQ-008 The block SHALL have port out_ready  input  1  consumer accepts the beat.
REQ-009 The block SHALL have port out_idx  output  4  binary index of the current set bit.
REQ-010 The block SHALL have port out_last  output  1  current beat is the final beat of the vector.
REQ-011 The block SHALL have port out_none  output  1  captured vector was all-zero; qualified by out_valid.
REQ-012 The block SHALL have port out_count  output  5  popcount of the captured vector, held for the whole burst.

Function
REQ-013 The FSM SHALL have two states, IDLE and EMIT.
REQ-014 In IDLE, in_ready SHALL be 1, out_valid SHALL be 0, and a cycle with in_valid=1 SHALL capture in_vec into the pending mask and enter EMIT on that edge.
REQ-015 out_valid SHALL rise the cycle after capture (latency 1); in_ready SHALL be 0 throughout EMIT.
REQ-016 In EMIT, out_idx SHALL be the index of the lowest set pending bit (LSB_FIRST=1) or highest (LSB_FIRST=0).
REQ-017 out_idx, out_last, out_none and out_count SHALL be derived from registered state only and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 On out_valid and out_ready, the emitted bit SHALL be cleared from the pending mask; the next beat follows in the next cycle with no bubble.
REQ-019 out_last SHALL be 1 when exactly one pending bit remains; acceptance of that beat SHALL return the FSM to IDLE on the same edge.
REQ-020 An all-zero in_vec SHALL produce exactly one beat with out_idx=0, out_none=1, out_last=1, out_count=0.
REQ-021 out_none SHALL be 0 for any non-zero vector.
REQ-022 out_count SHALL equal the popcount captured at accept time (range 0..16, 5 bits, no wrap) and SHALL NOT decrement during the burst.
REQ-023 A vector with all 16 bits set SHALL produce 16 beats, indices 0..15 in order (LSB_FIRST=1), with out_last only on index 15.
REQ-024 in_valid while in EMIT SHALL be ignored; the producer holds its vector until in_ready=1.
REQ-025 The first new vector SHALL be accepted no earlier than the cycle after the last beat is accepted (one IDLE cycle minimum between bursts).

Reset
REQ-026 While rst_n=0, the block SHALL be in IDLE, with pending mask=0, out_valid=0, out_idx=0, out_last=0, out_none=0, out_count=0 and in_ready=1, taking effect immediately without waiting for clk.
REQ-027 Reset asserted mid-burst SHALL discard all remaining beats, and no beat SHALL be emitted after deassertion until a new vector is accepted.
REQ-028 The first capture after reset SHALL occur no earlier than the first rising clk edge after rst_n deasserts.

Structure
REQ-029 Package encoder_pkg SHALL hold the state enum (IDLE, EMIT), VEC_W=16, IDX_W=4 and CNT_W=5.
REQ-030 Sub-module prio_find16 SHALL be a purely combinational lowest/highest set-bit finder with inputs mask and direction and outputs idx and found.
REQ-031 All other logic SHALL be in encoder16_stream.

Verification
REQ-032 in_vec=16'h0000 accepted, out_ready=1 -> one beat: idx=0, none=1, last=1, count=0; in_ready returns to 1.
REQ-033 in_vec=16'h8421, out_ready=1, LSB_FIRST=1 -> idx 0,5,10,15 on consecutive cycles; last only on 15; count=4 on every beat.
REQ-034 in_vec=16'h8421 with LSB_FIRST=0 -> idx 15,10,5,0.
REQ-035 in_vec=16'h0090, out_ready held low 5 cycles then high -> idx=4 held stable with out_valid=1 while stalled, then idx=7 with last=1.
REQ-036 in_vec=16'hFFFF accepted, rst_n pulsed low after the 3rd beat -> outputs at reset values immediately; no further beats; next vector 16'h0002 -> single beat idx=1, last=1.
REQ-037 in_valid held high with changing in_vec during EMIT -> only the originally captured vector is emitted.
